data_array_nway: RTL and testbench

//  N-way set-associative cache data store with a per-byte write mask and a

---
 rtl/cache_types_pkg.sv | 26 ++
 rtl/data_way_bank.sv | 56 +++++
 rtl/data_array_nway.sv | 123 ++++++++++++
 tb/tb_data_array_nway.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/cache_types_pkg.sv
// Shared types and sizing helpers for the cache data/tag arrays.
package cache_types_pkg;

  typedef enum logic {INIT, RUN} data_array_state_e;

  function automatic int unsigned calc_s_mask(input int unsigned s_offset);
    return 32'd1 << s_offset;
  endfunction

  function automatic int unsigned calc_s_line(input int unsigned s_offset);
    return 32'd8 * calc_s_mask(s_offset);
  endfunction

  function automatic int unsigned calc_num_sets(input int unsigned s_index);
    return 32'd1 << s_index;
  endfunction

  function automatic int unsigned calc_s_way(input int unsigned num_ways);
    return (num_ways > 32'd1) ? 32'($clog2(num_ways)) : 32'd1;
  endfunction

  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/data_way_bank.sv
// One way of the data array: per-byte masked write, write-first combinational read.
// Parity storage present only when DATA_ARRAY_PARITY_EN is defined.
module data_way_bank
  import cache_types_pkg::*;
#(
  parameter int unsigned s_offset = 5,
  parameter int unsigned s_index  = 3,
  localparam int unsigned s_mask   = calc_s_mask(s_offset),
  localparam int unsigned s_line   = calc_s_line(s_offset),
  localparam int unsigned num_sets = calc_num_sets(s_index)
) (
  input  logic                clk,
  input  logic [s_mask-1:0]   wmask,
  input  logic [s_index-1:0]  windex,
  input  logic [s_line-1:0]   wdata,
  input  logic [s_index-1:0]  rindex,
`ifdef DATA_ARRAY_PARITY_EN
  output logic [s_mask-1:0]   rpar_c,
`endif
  output logic [s_line-1:0]   rdata_c
);

  logic [s_line-1:0] mem [num_sets];

  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(s_mask); i++) begin
      if (wmask[i]) mem[windex][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  // Bytes being written to the set under read come straight from wdata.
  always_comb begin
    rdata_c = mem[rindex];
    for (int i = 0; i < int'(s_mask); i++) begin
      if (wmask[i] && (windex == rindex)) rdata_c[8*i +: 8] = wdata[8*i +: 8];
    end
  end

`ifdef DATA_ARRAY_PARITY_EN
  logic [s_mask-1:0] par [num_sets];

  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(s_mask); i++) begin
      if (wmask[i]) par[windex][i] <= byte_parity(wdata[8*i +: 8]);
    end
  end

  always_comb begin
    rpar_c = par[rindex];
    for (int i = 0; i < int'(s_mask); i++) begin
      if (wmask[i] && (windex == rindex)) rpar_c[i] = byte_parity(wdata[8*i +: 8]);
    end
  end
`endif

endmodule

// File: rtl/data_array_nway.sv
// N-way cache data store: post-reset clear sweep, masked writes, registered all-way read.
// Optional per-byte even parity with DATA_ARRAY_PARITY_EN.
module data_array_nway
  import cache_types_pkg::*;
#(
  parameter int unsigned s_offset = 5,
  parameter int unsigned s_index  = 3,
  parameter int unsigned num_ways = 2,
  localparam int unsigned s_mask   = calc_s_mask(s_offset),
  localparam int unsigned s_line   = calc_s_line(s_offset),
  localparam int unsigned num_sets = calc_num_sets(s_index),
  localparam int unsigned s_way    = calc_s_way(num_ways)
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         ready,
  input  logic                         read,
  input  logic [s_index-1:0]           rindex,
  input  logic [s_mask-1:0]            write_en,
  input  logic [s_way-1:0]             wway,
  input  logic [s_index-1:0]           windex,
  input  logic [s_line-1:0]            datain,
  output logic [num_ways*s_line-1:0]   dataout,
  output logic                         rvalid,
  output logic [num_ways-1:0]          perr
);

  localparam int unsigned cnt_w = s_index + 1;

  data_array_state_e state;
  logic [cnt_w-1:0]  cnt;

  logic                        sweep_c;
  logic                        run_c;
  logic [s_index-1:0]          bank_windex_c;
  logic [s_line-1:0]           bank_wdata_c;
  logic [num_ways*s_line-1:0]  rdata_c;

  assign sweep_c       = (state == INIT) && !rst;
  assign run_c         = (state == RUN) && !rst;
  assign bank_windex_c = sweep_c ? cnt[s_index-1:0] : windex;
  assign bank_wdata_c  = sweep_c ? '0 : datain;

`ifdef DATA_ARRAY_PARITY_EN
  logic [num_ways*s_mask-1:0] rpar_c;
  logic [num_ways-1:0]        perr_c;
`endif

  for (genvar w = 0; w < int'(num_ways); w++) begin : g_way
    logic [s_mask-1:0] wmask_c;

    // Sweep writes every way of the current set; in RUN only the addressed way.
    always_comb begin
      wmask_c = '0;
      if (sweep_c) wmask_c = '1;
      else if (run_c && (wway == s_way'(w))) wmask_c = write_en;
    end

    data_way_bank #(
      .s_offset (s_offset),
      .s_index  (s_index)
    ) u_bank (
      .clk     (clk),
      .wmask   (wmask_c),
      .windex  (bank_windex_c),
      .wdata   (bank_wdata_c),
      .rindex  (rindex),
`ifdef DATA_ARRAY_PARITY_EN
      .rpar_c  (rpar_c[w*s_mask +: s_mask]),
`endif
      .rdata_c (rdata_c[w*s_line +: s_line])
    );
  end

`ifdef DATA_ARRAY_PARITY_EN
  always_comb begin
    perr_c = '0;
    for (int w = 0; w < int'(num_ways); w++) begin
      for (int i = 0; i < int'(s_mask); i++) begin
        perr_c[w] = perr_c[w] |
                    (byte_parity(rdata_c[w*s_line + 8*i +: 8]) ^ rpar_c[w*s_mask + i]);
      end
    end
  end
`else
  assign perr = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= INIT;
      cnt     <= '0;
      ready   <= 1'b0;
      rvalid  <= 1'b0;
      dataout <= '0;
`ifdef DATA_ARRAY_PARITY_EN
      perr    <= '0;
`endif
    end else begin
      rvalid <= 1'b0;
      case (state)
        INIT: begin
          cnt <= cnt + cnt_w'(1);
          if (cnt == cnt_w'(num_sets - 1)) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        RUN: begin
          if (read) begin
            rvalid  <= 1'b1;
            dataout <= rdata_c;
`ifdef DATA_ARRAY_PARITY_EN
            perr    <= perr_c;
`endif
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_data_array_nway.sv
// Scoreboard bench for data_array_nway (default parameters); honours DATA_ARRAY_PARITY_EN.
module tb_data_array_nway;

  typedef struct packed {
    logic [511:0] d;
    logic [1:0]   p;
  } exp_t;

`ifdef DATA_ARRAY_PARITY_EN
  localparam logic [1:0] flip_perr = 2'b10;
`else
  localparam logic [1:0] flip_perr = 2'b00;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         ready;
  logic         read;
  logic [2:0]   rindex;
  logic [31:0]  write_en;
  logic [0:0]   wway;
  logic [2:0]   windex;
  logic [255:0] datain;
  logic [511:0] dataout;
  logic         rvalid;
  logic [1:0]   perr;

  int unsigned vec_cnt = 0;
  int unsigned err_cnt = 0;
  logic        exp_ready = 1'b0;
  logic [255:0] mem_m [2][8];
  exp_t        sb[$];
  exp_t        mon_e;

  always #5 clk = ~clk;

  data_array_nway dut (
    .clk      (clk),
    .rst      (rst),
    .ready    (ready),
    .read     (read),
    .rindex   (rindex),
    .write_en (write_en),
    .wway     (wway),
    .windex   (windex),
    .datain   (datain),
    .dataout  (dataout),
    .rvalid   (rvalid),
    .perr     (perr)
  );

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] rep(input logic [7:0] b);
    return {32{b}};
  endfunction

  task automatic model_clear();
    for (int w = 0; w < 2; w++)
      for (int s = 0; s < 8; s++) mem_m[w][s] = '0;
  endtask

  // Drive one cycle; push the expected read result and update the model.
  task automatic do_cycle(input logic rd, input logic [2:0] ri, input logic [31:0] we,
                          input logic ww, input logic [2:0] wi, input logic [255:0] din,
                          input logic [1:0] ep);
    exp_t e;
    read = rd; rindex = ri; write_en = we; wway = ww; windex = wi; datain = din;
    if (exp_ready && rd) begin
      e.d = {mem_m[1][ri], mem_m[0][ri]};
      if (wi == ri)
        for (int i = 0; i < 32; i++)
          if (we[i]) e.d[int'(ww)*256 + 8*i +: 8] = din[8*i +: 8];
      e.p = ep;
      sb.push_back(e);
    end
    if (exp_ready)
      for (int i = 0; i < 32; i++)
        if (we[i]) mem_m[ww][wi][8*i +: 8] = din[8*i +: 8];
    tick();
    read = 1'b0; write_en = '0;
  endtask

  task automatic rd_only(input logic [2:0] ri);
    do_cycle(1'b1, ri, 32'h0, 1'b0, 3'd0, '0, 2'b00);
  endtask

  task automatic wr_only(input logic ww, input logic [2:0] wi, input logic [31:0] we,
                         input logic [255:0] din);
    do_cycle(1'b0, 3'd0, we, ww, wi, din, 2'b00);
  endtask

  always @(negedge clk) begin
    if (rvalid) begin
      if (sb.size() == 0) begin
        check("spurious_rvalid", 512'(rvalid), 512'(0));
      end else begin
        mon_e = sb.pop_front();
        check("dataout", dataout, mon_e.d);
        check("perr", 512'(perr), 512'(mon_e.p));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [255:0] tmp;
    logic [255:0] rd_data;
    rst = 1'b1; read = 1'b0; rindex = '0; write_en = '0; wway = '0; windex = '0; datain = '0;
    tick(); tick();
    check("rst_ready", 512'(ready), 512'(0));
    check("rst_rvalid", 512'(rvalid), 512'(0));
    check("rst_dataout", dataout, 512'(0));
    check("rst_perr", 512'(perr), 512'(0));

    // Sweep length: ready low for exactly 8 cycles.
    rst = 1'b0;
    model_clear();
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("sweep_ready_%0d", k), 512'(ready), 512'(k == 8));
    end
    exp_ready = 1'b1;

    rd_only(3'd5);

    wr_only(1'b1, 3'd3, 32'h0000_000F, rep(8'hA5));
    rd_only(3'd3);
    tick(); tick();
    check("dataout_hold", dataout, {mem_m[1][3], mem_m[0][3]});
    check("rvalid_idle", 512'(rvalid), 512'(0));

    // Write-first forwarding on a partly populated line.
    wr_only(1'b0, 3'd2, 32'h0000_0F00, rep(8'h5A));
    do_cycle(1'b1, 3'd2, 32'h8000_0001, 1'b0, 3'd2, rep(8'h3C), 2'b00);
    rd_only(3'd2);

    // Back-to-back reads of all sets.
    for (int s = 0; s < 8; s++) rd_only(3'(s));

    for (int n = 0; n < 40; n++) begin
      for (int j = 0; j < 8; j++) rd_data[32*j +: 32] = $urandom;
      do_cycle(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
               ($urandom_range(0, 3) == 0) ? 32'h0 : 32'($urandom),
               1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), rd_data, 2'b00);
    end

    // Corrupt one stored bit behind the array's back.
    wr_only(1'b0, 3'd6, 32'hFFFF_FFFF, rep(8'h81));
    wr_only(1'b1, 3'd6, 32'hFFFF_FFFF, rep(8'h17));
    tmp = dut.g_way[1].u_bank.mem[6];
    tmp[77] = ~tmp[77];
    dut.g_way[1].u_bank.mem[6] = tmp;
    mem_m[1][6][77] = ~mem_m[1][6][77];
    do_cycle(1'b1, 3'd6, 32'h0, 1'b0, 3'd0, '0, flip_perr);
    tick(); tick();

    // Reset again, then reset mid-sweep.
    rst = 1'b1;
    exp_ready = 1'b0;
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check($sformatf("sweep2_ready_%0d", k), 512'(ready), 512'(0));
    end
    rst = 1'b1;
    tick();
    check("midsweep_rst_ready", 512'(ready), 512'(0));
    rst = 1'b0;
    model_clear();
    for (int k = 1; k <= 8; k++) begin
      if (k == 3) begin
        read = 1'b1; rindex = 3'd0;
        write_en = 32'hFFFF_FFFF; wway = 1'b0; windex = 3'd0; datain = rep(8'hFF);
      end
      tick();
      read = 1'b0; write_en = '0;
      check($sformatf("sweep3_ready_%0d", k), 512'(ready), 512'(k == 8));
    end
    exp_ready = 1'b1;
    for (int s = 0; s < 8; s++) rd_only(3'(s));

    tick(); tick(); tick();
    check("sb_drain", 512'(sb.size()), 512'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
